// File: rtl/uart_tx_mmio_if.sv
// Memory-mapped bus between the CPU data-memory stage and the UART transmitter.
// Latency: address decode and read data are combinational; writes land on the next clock edge.
// Backpressure: none on the bus; a full transmit FIFO drops the byte and flags overflow instead.
// Signals: address/data/MemRead/MemWrite from the CPU, rd_data/UartAddress back to it.
interface uart_tx_mmio_if;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd_data;
    logic        UartAddress;

    modport master (
        output address, data, MemRead, MemWrite,
        input  rd_data, UartAddress
    );

    modport slave (
        input  address, data, MemRead, MemWrite,
        output rd_data, UartAddress
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: TXDATA/STATUS/CTRL/ACK registers, byte FIFO, 8N1 serialiser, sticky irq.
// Latency: TXDATA write at edge k into idle/empty -> start bit driven from edge k+1; frame is 10*BAUD_DIV cycles.
// Backpressure: none; a push into a full FIFO with no simultaneous pop is dropped and sets overflow.
// Ports: clk, reset (async, active-high), bus (slave side of uart_tx_mmio_if),
//        UartInterrupt (registered sticky level), tx (registered serial line, idles high).
module uart_tx_mmio #(
    parameter int BAUD_DIV = 16,
    parameter int DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          UartInterrupt,
    output logic          tx
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0010;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0014;
    localparam logic [31:0] ADDR_CTRL   = 32'hFFFF_0018;
    localparam logic [31:0] ADDR_ACK    = 32'hFFFF_001C;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ie_q, ovf_q, irq_q;

    // Address decode, exact 32-bit match only.
    logic sel_tx, sel_st, sel_ctrl, sel_ack;
    assign sel_tx   = (bus.address == ADDR_TXDATA);
    assign sel_st   = (bus.address == ADDR_STATUS);
    assign sel_ctrl = (bus.address == ADDR_CTRL);
    assign sel_ack  = (bus.address == ADDR_ACK);
    assign bus.UartAddress = sel_tx | sel_st | sel_ctrl | sel_ack;

    logic wr_tx, wr_ctrl, wr_ack;
    assign wr_tx   = bus.MemWrite & sel_tx;
    assign wr_ctrl = bus.MemWrite & sel_ctrl;
    assign wr_ack  = bus.MemWrite & sel_ack;

    logic fifo_full, fifo_empty, pop, push, ovf_set, frame_done, irq_set;
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push       = wr_tx && (!fifo_full || pop);
    assign ovf_set    = wr_tx && fifo_full && !pop;
    // Pre-edge emptiness: no pop can coincide with the STOP->IDLE edge.
    assign irq_set    = frame_done && fifo_empty && ie_q;

    logic unused_data_hi;
    assign unused_data_hi = ^bus.data[31:8];

    // STATUS count field saturates at 7 for deeper FIFOs.
    logic [2:0]  cnt_sat;
    logic [31:0] rd_data_c;
    assign cnt_sat = (32'(count_q) > 32'd7) ? 3'd7 : 3'(count_q);

    always_comb begin
        rd_data_c = '0;
        if (bus.MemRead) begin
            if (sel_st) begin
                rd_data_c = {25'b0, ovf_q, cnt_sat, (state_q != IDLE), fifo_empty, fifo_full};
            end else if (sel_ctrl) begin
                rd_data_c = {31'b0, ie_q};
            end
        end
    end
    assign bus.rd_data = rd_data_c;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    logic baud_last;
    assign baud_last = (baud_q == 16'(BAUD_DIV - 1));

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d    = IDLE;
                    baud_d     = '0;
                    frame_done = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ie_q     <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_ctrl) ie_q <= bus.data[0];
            ovf_q <= ovf_set | (ovf_q & ~wr_ack);
            // A new interrupt condition wins over a same-cycle ACK.
            irq_q <= irq_set | (irq_q & ~wr_ack);
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.data[7:0];
    end

    assign tx            = tx_q;
    assign UartInterrupt = irq_q;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random bus traffic against a timing-level model.
// Accepted bytes are queued as expected frames; a line monitor decodes tx and pops/compares them.
// Status, control reads and the interrupt line are checked against the model every cycle/read.
module tb_uart_tx_mmio;
    localparam int B     = 4;
    localparam int D     = 4;
    localparam int FRAME = 10 * B;
    localparam logic [31:0] A_TX  = 32'hFFFF_0010;
    localparam logic [31:0] A_ST  = 32'hFFFF_0014;
    localparam logic [31:0] A_CT  = 32'hFFFF_0018;
    localparam logic [31:0] A_AK  = 32'hFFFF_001C;
    localparam logic [31:0] A_BAD = 32'hFFFF_0020;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic UartInterrupt, tx;
    bit   chk_en = 1'b0;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(.BAUD_DIV(B), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .UartInterrupt(UartInterrupt), .tx(tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, frame timing by edge number, sticky bits.
    int         ecnt = 0;
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    bit         m_active = 0;
    int         m_last_pop = 0;
    bit         m_ie = 0, m_ovf = 0, m_irq = 0;

    always @(posedge clk or posedge reset) begin
        int sz;
        bit pop, set_irq;
        if (reset) begin
            m_fifo.delete();
            exp_q.delete();
            m_active = 0; m_last_pop = 0;
            m_ie = 0; m_ovf = 0; m_irq = 0;
        end else begin
            sz = m_fifo.size();
            ecnt++;
            // Transmitter takes a new byte only once a frame plus its idle cycle has elapsed.
            pop = (sz > 0) && (!m_active || ecnt >= m_last_pop + FRAME + 1);
            set_irq = m_active && (ecnt == m_last_pop + FRAME) && (sz == 0) && m_ie;
            if (pop) begin
                void'(m_fifo.pop_front());
                m_active = 1;
                m_last_pop = ecnt;
            end
            if (bus.MemWrite && bus.address == A_TX) begin
                if (sz < D || pop) begin
                    m_fifo.push_back(bus.data[7:0]);
                    exp_q.push_back(bus.data[7:0]);
                end else begin
                    m_ovf = 1;
                end
            end
            if (bus.MemWrite && bus.address == A_CT) m_ie = bus.data[0];
            if (bus.MemWrite && bus.address == A_AK) begin
                m_irq = 0;
                m_ovf = 0;
            end
            if (set_irq) m_irq = 1;
        end
    end

    function automatic logic [31:0] m_status();
        int sz;
        logic [2:0] c;
        bit busy;
        sz   = m_fifo.size();
        c    = (sz > 7) ? 3'd7 : 3'(sz);
        busy = m_active && (ecnt - m_last_pop < FRAME);
        return {25'b0, m_ovf, c, busy, (sz == 0), (sz == D)};
    endfunction

    // Interrupt line compared to the model one step after every edge.
    always @(posedge clk) begin
        #1;
        if (chk_en && !reset) check("irq_level", UartInterrupt, m_irq);
    end

    // Line monitor: decodes frames from negedge samples and scores them.
    initial begin : monitor
        logic [7:0] byte_v;
        logic       bitv;
        bit         ok, abort;
        bitv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || tx !== 1'b0) continue;
            ok = 1; abort = 0; byte_v = '0;
            for (int s = 1; s < B; s++) begin
                @(negedge clk);
                if (reset) abort = 1;
                else if (tx !== 1'b0) ok = 0;
            end
            for (int b = 0; b < 8; b++) begin
                for (int s = 0; s < B; s++) begin
                    @(negedge clk);
                    if (reset) abort = 1;
                    else if (s == 0) bitv = tx;
                    else if (tx !== bitv) ok = 0;
                end
                byte_v[b] = bitv;
            end
            for (int s = 0; s < B; s++) begin
                @(negedge clk);
                if (reset) abort = 1;
                else if (tx !== 1'b1) ok = 0;
            end
            if (!abort) begin
                check("frame_shape", 32'(ok), 1);
                check("frame_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("frame_byte", byte_v, exp_q.pop_front());
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.address  = a;
        bus.data     = d;
        bus.MemWrite = 1'b1;
        @(negedge clk);
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.address = a;
        bus.MemRead = 1'b1;
        #1;
        check(name, bus.rd_data, exp);
        bus.MemRead = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            done = (m_fifo.size() == 0) && (exp_q.size() == 0) &&
                   !(m_active && (ecnt - m_last_pop < FRAME));
        end
        check("drain_done", 32'(done), 1);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic seq_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] addrs [4] = '{A_TX, A_ST, A_CT, A_AK};

    initial begin
        int k, lows;
        bit seen;
        bus.address = '0; bus.data = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_irq", UartInterrupt, 0);
        rd_check("rst_status", A_ST, 32'h2);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Decode: the four block addresses hit, a neighbour misses, no read -> 0.
        for (int i = 0; i < 4; i++) begin
            bus.address = addrs[i];
            #1 check("decode_hit", bus.UartAddress, 1);
        end
        bus.address = A_BAD;
        #1 check("decode_miss", bus.UartAddress, 0);
        bus.address = A_ST;
        #1 check("rd_no_memread", bus.rd_data, 0);
        @(negedge clk);

        // 0xA5 frame: line still high before the pop edge, then exact bit sequence.
        do_write(A_TX, 32'h0000_00A5);
        check("pre_pop_tx", tx, 1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a5_bit", tx, seq_a5[i]);
            if (i == 3) rd_check("status_busy", A_ST, 32'h6);
            repeat (3) @(negedge clk);
        end
        rd_check("status_after_frame", A_ST, 32'h2);
        wait_idle();

        // Interrupt latency, ie-clear keeps it pending, ACK clears it.
        do_write(A_CT, 32'h1);
        rd_check("ctrl_ie", A_CT, 32'h1);
        do_write(A_TX, 32'h0);
        k = ecnt;
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (UartInterrupt) seen = 1;
            else @(negedge clk);
        end
        check("irq_seen", 32'(seen), 1);
        check("irq_latency", ecnt - k, 41);
        do_write(A_CT, 32'h0);
        check("irq_kept_ie0", UartInterrupt, 1);
        do_write(A_AK, 32'hDEAD_BEEF);
        check("irq_ack", UartInterrupt, 0);

        // ACK on the exact set edge: set wins.
        do_write(A_CT, 32'h1);
        do_write(A_TX, 32'h3C);
        for (int n = 0; n < 100 && ecnt != m_last_pop + FRAME - 1; n++) @(negedge clk);
        do_write(A_AK, 32'h0);
        check("irq_set_wins", UartInterrupt, 1);
        do_write(A_AK, 32'h0);
        check("irq_ack2", UartInterrupt, 0);
        do_write(A_CT, 32'h0);
        wait_idle();

        // Five back-to-back pushes fill the FIFO, sixth overflows and is dropped.
        for (int i = 0; i < 5; i++) do_write(A_TX, 32'h11 + i);
        rd_check("status_full", A_ST, 32'h25);
        rd_check("status_full_model", A_ST, m_status());
        do_write(A_TX, 32'h66);
        rd_check("status_ovf", A_ST, 32'h65);
        do_write(A_AK, 32'h0);
        rd_check("status_ovf_ack", A_ST, 32'h25);
        wait_idle();

        // Out-of-map access: no decode, no data, no state change.
        bus.address = A_BAD; bus.data = 32'h1; bus.MemWrite = 1'b1; bus.MemRead = 1'b1;
        #1 check("bad_decode", bus.UartAddress, 0);
        check("bad_rdata", bus.rd_data, 0);
        @(negedge clk);
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        rd_check("bad_status", A_ST, 32'h2);
        rd_check("bad_ctrl", A_CT, 32'h0);

        // Random traffic, heavy enough to keep the FIFO full and overlap push with pop.
        for (int it = 0; it < 600; it++) begin
            int r, j;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                do_write(A_TX, $urandom);
            end else if (r == 4) begin
                do_write(A_CT, $urandom);
            end else if (r == 5) begin
                do_write(A_AK, $urandom);
            end else if (r <= 7) begin
                j = $urandom_range(0, 3);
                case (j)
                    0:       rd_check("rnd_txdata", A_TX, 32'h0);
                    1:       rd_check("rnd_status", A_ST, m_status());
                    2:       rd_check("rnd_ctrl", A_CT, 32'(m_ie));
                    default: rd_check("rnd_ack", A_AK, 32'h0);
                endcase
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        do_write(A_CT, 32'h0);
        do_write(A_AK, 32'h0);
        wait_idle();

        // Reset 15 cycles into a 0x5A frame (data bit 2 = 0 on the line).
        do_write(A_TX, 32'h5A);
        for (int n = 0; n < 100 && ecnt != m_last_pop + 15; n++) @(negedge clk);
        check("pre_reset_tx", tx, 0);
        #2 reset = 1'b1;
        #1 check("reset_tx_async", tx, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd_check("post_reset_status", A_ST, 32'h2);
        lows = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frame_after_reset", lows, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
